idecode: RTL and testbench
==========================

Name: idecode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline. Sits directly downstream of the fetch stage and consumes its IF_ID_instr and IF_ID_npc outputs.
- Contains the 32x32 register file, the main control decoder and the sign extender.
- Detects load-use hazards and drives a stall back to fetch.
- Registers all decoded results into the ID/EX pipeline latch.

Parameters:
- DATA_W, 32, datapath and register width
- REG_AW, 5, register address width (32 registers)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- IF_ID_instr  input  32  instruction from the IF/ID latch
- IF_ID_npc  input  32  PC+4 from the IF/ID latch
- MEM_WB_RegWrite  input  1  writeback enable
- MEM_WB_WriteReg  input  5  writeback destination register
- MEM_WB_WriteData  input  32  writeback data
- EX_MEM_PCSrc  input  1  taken branch; flush the instruction in decode
- stall  output  1  combinational; high means hold PC and IF/ID this cycle
- ID_EX_WB  output  2  {RegWrite, MemtoReg}
- ID_EX_M  output  3  {Branch, MemRead, MemWrite}
- ID_EX_EX  output  4  {RegDst, ALUOp[1:0], ALUSrc}
- ID_EX_npc  output  32  registered IF_ID_npc
- ID_EX_readdat1  output  32  registered rs value
- ID_EX_readdat2  output  32  registered rt value
- ID_EX_sign_ext  output  32  registered sign-extended instr[15:0]
- ID_EX_instr_2016  output  5  registered rt field
- ID_EX_instr_1511  output  5  registered rd field

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ID_EX_* outputs go to 0.
  - All 32 registers clear to 0.
  - Reset mid-operation discards any pending writeback.
- Register file:
  - Written on the rising clk edge when MEM_WB_RegWrite=1 and MEM_WB_WriteReg!=0.
  - Register 0 always reads 0.
  - Reads are combinational with write-through bypass: if MEM_WB_RegWrite=1, WriteReg equals the read address and the address is not 0, the read returns MEM_WB_WriteData in the same cycle.
- Control decode (opcode = IF_ID_instr[31:26]), given as WB / M / EX:
  - 0x00 R-type: 10 / 000 / 1_10_0
  - 0x23 lw: 11 / 010 / 0_00_1
  - 0x2B sw: 00 / 001 / 0_00_1
  - 0x04 beq: 00 / 100 / 0_01_0
  - Any other opcode: all control bits 0 (treated as a NOP).
- Sign extension: instr[15] is replicated into bits 31:16.
- Latency: exactly one clk from IF_ID_* to ID_EX_*. Every data field latches every cycle.
- Hazard detection: stall=1 when all of the following hold:
  - ID_EX_M[1] (MemRead) = 1, and
  - ID_EX_instr_2016 != 0, and
  - ID_EX_instr_2016 equals rs, or equals rt when the current opcode is R-type, sw or beq.
- On stall: the next ID_EX_WB/M/EX are forced to 0 (bubble). The data fields still latch. stall deasserts the following cycle because the bubble has MemRead=0.
- On EX_MEM_PCSrc=1: the next ID_EX_WB/M/EX are forced to 0 (flush).
- Simultaneous flush and stall: flush wins. stall is still reported, because upstream gating is handled in fetch.
- Simultaneous writeback and read of the same register: the bypass value is used, with no extra cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - ALUOp encodings
  - WB/M/EX field widths and bit positions, shared with the EX and MEM stages
- One natural sub-module: regfile (32x32, 2 combinational read ports, 1 write port, bypass, r0 hardwired to 0).
- Control decode and hazard logic stay inline.

Test Plan:
1. Reset then release; IF_ID_instr=0x8C220004 (lw $2,4($1)) -> after one clk: ID_EX_WB=11, ID_EX_M=010, ID_EX_EX=0001, ID_EX_sign_ext=0x00000004, ID_EX_instr_2016=2.
2. Writeback r5=0xDEADBEEF while decoding add $3,$5,$0 (0x00A01820) in the same cycle -> ID_EX_readdat1=0xDEADBEEF next cycle; a later read of r5 returns the same value.
3. Writeback to r0 with data 0x1234 -> a subsequent read of r0 returns 0x00000000.
4. lw $2,0($1) followed by add $4,$2,$3 -> stall=1 for exactly one cycle, one bubble (all control 0) appears in ID/EX, then the add decodes with WB=10.
5. Decode beq (0x1022FFFE) with EX_MEM_PCSrc=1 -> ID_EX control = 0. Check sign_ext=0xFFFFFFFE.
6. Assert rst_n low mid-stream with regfile loaded -> ID_EX_* read 0 immediately without waiting for a clk edge; all registers read 0 afterwards. Unknown opcode 0x3F -> all control 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp codes and
// the WB/M/EX control bundle layouts used by ID, EX and MEM.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/regfile.sv
// 32-entry register file, 2 async read ports with write-through
// bypass, 1 write port; r0 reads as zero.
// Ports: clk, rst_n, i_we/i_waddr/i_wdata (write),
//        i_raddr1/2 -> o_rdata1/2 (combinational reads).
module regfile #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   localparam int NREG = 1 << REG_AW;

   logic [DATA_W-1:0] r_mem [NREG];
   logic              w_wen;
   logic              w_byp1;
   logic              w_byp2;

   assign w_wen = i_we && (i_waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wen) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Same-cycle writeback is forwarded so decode needs no extra cycle.
   assign w_byp1 = w_wen && (i_waddr == i_raddr1);
   assign w_byp2 = w_wen && (i_waddr == i_raddr2);

   assign o_rdata1 = (i_raddr1 == '0) ? '0 :
                     w_byp1 ? i_wdata : r_mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? '0 :
                     w_byp2 ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: register file, control decode,
// sign extension, load-use hazard detection and the ID/EX latch.
// Ports: IF_ID_* in, MEM_WB_* writeback in, EX_MEM_PCSrc flush in,
//        stall out (comb), ID_EX_* registered outputs.
module idecode
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       IF_ID_instr,
   input  logic [31:0]       IF_ID_npc,
   input  logic              MEM_WB_RegWrite,
   input  logic [REG_AW-1:0] MEM_WB_WriteReg,
   input  logic [DATA_W-1:0] MEM_WB_WriteData,
   input  logic              EX_MEM_PCSrc,
   output logic              stall,
   output logic [WB_W-1:0]   ID_EX_WB,
   output logic [M_W-1:0]    ID_EX_M,
   output logic [EX_W-1:0]   ID_EX_EX,
   output logic [31:0]       ID_EX_npc,
   output logic [DATA_W-1:0] ID_EX_readdat1,
   output logic [DATA_W-1:0] ID_EX_readdat2,
   output logic [DATA_W-1:0] ID_EX_sign_ext,
   output logic [REG_AW-1:0] ID_EX_instr_2016,
   output logic [REG_AW-1:0] ID_EX_instr_1511
);

   logic [5:0]        w_op;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [15:0]       w_imm;
   logic [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [WB_W-1:0]   w_wb;
   logic [M_W-1:0]    w_m;
   logic [EX_W-1:0]   w_ex;
   logic              w_uses_rt;
   logic              w_bubble;

   assign w_op  = IF_ID_instr[31:26];
   assign w_rs  = IF_ID_instr[25:21];
   assign w_rt  = IF_ID_instr[20:16];
   assign w_rd  = IF_ID_instr[15:11];
   assign w_imm = IF_ID_instr[15:0];

   assign w_sext = {{(DATA_W-16){w_imm[15]}}, w_imm};

   regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (MEM_WB_RegWrite),
      .i_waddr  (MEM_WB_WriteReg),
      .i_wdata  (MEM_WB_WriteData),
      .i_raddr1 (w_rs),
      .i_raddr2 (w_rt),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2)
   );

   always_comb begin
      w_wb = '0;
      w_m  = '0;
      w_ex = '0;
      unique case (1'b1)
         (w_op == OP_RTYPE): begin
            w_wb[WB_REGWRITE] = 1'b1;
            w_ex[EX_REGDST]   = 1'b1;
            w_ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALUOP_FUNCT;
         end
         (w_op == OP_LW): begin
            w_wb[WB_REGWRITE] = 1'b1;
            w_wb[WB_MEMTOREG] = 1'b1;
            w_m[M_MEMREAD]    = 1'b1;
            w_ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALUOP_ADD;
            w_ex[EX_ALUSRC]   = 1'b1;
         end
         (w_op == OP_SW): begin
            w_m[M_MEMWRITE] = 1'b1;
            w_ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALUOP_ADD;
            w_ex[EX_ALUSRC] = 1'b1;
         end
         (w_op == OP_BEQ): begin
            w_m[M_BRANCH] = 1'b1;
            w_ex[EX_ALUOP_HI:EX_ALUOP_LO] = ALUOP_SUB;
         end
         default: ;
      endcase
   end

   // rt is only a source operand for R-type, sw and beq.
   assign w_uses_rt = (w_op == OP_RTYPE) ||
                      (w_op == OP_SW)    ||
                      (w_op == OP_BEQ);

   assign stall = ID_EX_M[M_MEMREAD] &&
                  (ID_EX_instr_2016 != '0) &&
                  ((ID_EX_instr_2016 == w_rs) ||
                   (w_uses_rt && (ID_EX_instr_2016 == w_rt)));

   // Stall inserts a bubble; a taken branch flushes. Either zeroes control.
   assign w_bubble = stall || EX_MEM_PCSrc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ID_EX_WB         <= '0;
         ID_EX_M          <= '0;
         ID_EX_EX         <= '0;
         ID_EX_npc        <= '0;
         ID_EX_readdat1   <= '0;
         ID_EX_readdat2   <= '0;
         ID_EX_sign_ext   <= '0;
         ID_EX_instr_2016 <= '0;
         ID_EX_instr_1511 <= '0;
      end else begin
         ID_EX_WB         <= w_bubble ? '0 : w_wb;
         ID_EX_M          <= w_bubble ? '0 : w_m;
         ID_EX_EX         <= w_bubble ? '0 : w_ex;
         ID_EX_npc        <= IF_ID_npc;
         ID_EX_readdat1   <= w_rd1;
         ID_EX_readdat2   <= w_rd2;
         ID_EX_sign_ext   <= w_sext;
         ID_EX_instr_2016 <= w_rt;
         ID_EX_instr_1511 <= w_rd;
      end
   end

endmodule

// File: tb/tb_idecode.sv
// Testbench for idecode: table-driven decode vectors plus
// hand sequences for bypass, hazard, flush and async reset.
module tb_idecode;

   logic        clk;
   logic        rst_n;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_npc;
   logic        MEM_WB_RegWrite;
   logic [4:0]  MEM_WB_WriteReg;
   logic [31:0] MEM_WB_WriteData;
   logic        EX_MEM_PCSrc;
   logic        stall;
   logic [1:0]  ID_EX_WB;
   logic [2:0]  ID_EX_M;
   logic [3:0]  ID_EX_EX;
   logic [31:0] ID_EX_npc;
   logic [31:0] ID_EX_readdat1;
   logic [31:0] ID_EX_readdat2;
   logic [31:0] ID_EX_sign_ext;
   logic [4:0]  ID_EX_instr_2016;
   logic [4:0]  ID_EX_instr_1511;

   idecode dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .IF_ID_instr      (IF_ID_instr),
      .IF_ID_npc        (IF_ID_npc),
      .MEM_WB_RegWrite  (MEM_WB_RegWrite),
      .MEM_WB_WriteReg  (MEM_WB_WriteReg),
      .MEM_WB_WriteData (MEM_WB_WriteData),
      .EX_MEM_PCSrc     (EX_MEM_PCSrc),
      .stall            (stall),
      .ID_EX_WB         (ID_EX_WB),
      .ID_EX_M          (ID_EX_M),
      .ID_EX_EX         (ID_EX_EX),
      .ID_EX_npc        (ID_EX_npc),
      .ID_EX_readdat1   (ID_EX_readdat1),
      .ID_EX_readdat2   (ID_EX_readdat2),
      .ID_EX_sign_ext   (ID_EX_sign_ext),
      .ID_EX_instr_2016 (ID_EX_instr_2016),
      .ID_EX_instr_1511 (ID_EX_instr_1511)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sext;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] npc;
      logic        stl;
      exp_t        e;
   } vec_t;

   int   n_chk;
   int   n_fail;
   exp_t q[$];
   vec_t tv[6];

   function automatic exp_t mk(
      logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
      logic [31:0] npc, logic [31:0] rd1, logic [31:0] rd2,
      logic [31:0] sext, logic [4:0] rt, logic [4:0] rd);
      exp_t e;
      e.wb = wb; e.m = m; e.ex = ex; e.npc = npc;
      e.rd1 = rd1; e.rd2 = rd2; e.sext = sext;
      e.rt = rt; e.rd = rd;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp(string tag, exp_t e);
      chk({tag, " WB"}, {30'd0, ID_EX_WB}, {30'd0, e.wb});
      chk({tag, " M"}, {29'd0, ID_EX_M}, {29'd0, e.m});
      chk({tag, " EX"}, {28'd0, ID_EX_EX}, {28'd0, e.ex});
      chk({tag, " npc"}, ID_EX_npc, e.npc);
      chk({tag, " rd1"}, ID_EX_readdat1, e.rd1);
      chk({tag, " rd2"}, ID_EX_readdat2, e.rd2);
      chk({tag, " sext"}, ID_EX_sign_ext, e.sext);
      chk({tag, " rt"}, {27'd0, ID_EX_instr_2016}, {27'd0, e.rt});
      chk({tag, " rd"}, {27'd0, ID_EX_instr_1511}, {27'd0, e.rd});
   endtask

   // Drive one cycle of inputs, push expectation, check stall
   // before the edge, then pop and compare just after it.
   task automatic cyc(string tag, logic [31:0] instr,
                      logic [31:0] npc, logic we, logic [4:0] wr,
                      logic [31:0] wd, logic pcsrc, logic stl,
                      exp_t e);
      exp_t g;
      IF_ID_instr      = instr;
      IF_ID_npc        = npc;
      MEM_WB_RegWrite  = we;
      MEM_WB_WriteReg  = wr;
      MEM_WB_WriteData = wd;
      EX_MEM_PCSrc     = pcsrc;
      q.push_back(e);
      #1;
      chk({tag, " stall"}, {31'd0, stall}, {31'd0, stl});
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s scoreboard: got empty expected entry", tag);
      end else begin
         g = q.pop_front();
         cmp(tag, g);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      IF_ID_instr = '0;
      IF_ID_npc = '0;
      MEM_WB_RegWrite = 1'b0;
      MEM_WB_WriteReg = '0;
      MEM_WB_WriteData = '0;
      EX_MEM_PCSrc = 1'b0;

      tv[0] = '{32'h8C220004, 32'h104, 1'b0,
         mk(2'b11, 3'b010, 4'b0001, 32'h104, 0, 0,
            32'h4, 5'd2, 5'd0)};
      tv[1] = '{32'hAC030008, 32'h108, 1'b0,
         mk(2'b00, 3'b001, 4'b0001, 32'h108, 0, 0,
            32'h8, 5'd3, 5'd0)};
      tv[2] = '{32'h10430010, 32'h10C, 1'b0,
         mk(2'b00, 3'b100, 4'b0010, 32'h10C, 0, 0,
            32'h10, 5'd3, 5'd0)};
      tv[3] = '{32'h00A01820, 32'h110, 1'b0,
         mk(2'b10, 3'b000, 4'b1100, 32'h110, 0, 0,
            32'h1820, 5'd0, 5'd3)};
      tv[4] = '{32'hFC00FFFF, 32'h114, 1'b0,
         mk(2'b00, 3'b000, 4'b0000, 32'h114, 0, 0,
            32'hFFFFFFFF, 5'd0, 5'd31)};
      tv[5] = '{32'h8C24FFF0, 32'h118, 1'b0,
         mk(2'b11, 3'b010, 4'b0001, 32'h118, 0, 0,
            32'hFFFFFFF0, 5'd4, 5'd31)};

      // Reset state
      #12;
      chk("reset stall", {31'd0, stall}, 32'd0);
      cmp("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Decode table
      for (int i = 0; i < 6; i++) begin
         cyc($sformatf("tv%0d", i), tv[i].instr, tv[i].npc,
             1'b0, 5'd0, 32'd0, 1'b0, tv[i].stl, tv[i].e);
      end

      // Writeback bypass into r5, then stored value
      cyc("byp", 32'h00A01820, 32'h200, 1'b1, 5'd5,
          32'hDEADBEEF, 1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h200, 32'hDEADBEEF, 0,
             32'h1820, 5'd0, 5'd3));
      cyc("r5", 32'h00A01820, 32'h204, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h204, 32'hDEADBEEF, 0,
             32'h1820, 5'd0, 5'd3));

      // Write to r0 is ignored, bypass included
      cyc("r0w", 32'h00001820, 32'h208, 1'b1, 5'd0,
          32'h1234, 1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h208, 0, 0,
             32'h1820, 5'd0, 5'd3));
      cyc("r0r", 32'h00001820, 32'h20C, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h20C, 0, 0,
             32'h1820, 5'd0, 5'd3));

      // Load-use: lw $2 then add $4,$2,$3
      cyc("lu lw", 32'h8C220000, 32'h300, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b11, 3'b010, 4'b0001, 32'h300, 0, 0,
             0, 5'd2, 5'd0));
      cyc("lu bub", 32'h00432020, 32'h304, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b1,
          mk(0, 0, 0, 32'h304, 0, 0, 32'h2020, 5'd3, 5'd4));
      cyc("lu add", 32'h00432020, 32'h304, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h304, 0, 0,
             32'h2020, 5'd3, 5'd4));

      // Flush together with stall: flush wins, stall reported
      cyc("fl lw", 32'h8C220000, 32'h400, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b11, 3'b010, 4'b0001, 32'h400, 0, 0,
             0, 5'd2, 5'd0));
      cyc("fl beq", 32'h1022FFFE, 32'h404, 1'b0, 5'd0, 32'd0,
          1'b1, 1'b1,
          mk(0, 0, 0, 32'h404, 0, 0, 32'hFFFFFFFE,
             5'd2, 5'd31));
      cyc("beq", 32'h1022FFFE, 32'h408, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(0, 3'b100, 4'b0010, 32'h408, 0, 0, 32'hFFFFFFFE,
             5'd2, 5'd31));
      cyc("fl only", 32'h00A01820, 32'h40C, 1'b0, 5'd0, 32'd0,
          1'b1, 1'b0,
          mk(0, 0, 0, 32'h40C, 32'hDEADBEEF, 0, 32'h1820,
             5'd0, 5'd3));

      // Load r7, confirm r5/r7, then async reset mid-cycle
      cyc("r7w", 32'h00A71820, 32'h500, 1'b1, 5'd7,
          32'h000055AA, 1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h500, 32'hDEADBEEF,
             32'h55AA, 32'h1820, 5'd7, 5'd3));
      cyc("r7r", 32'h00A71820, 32'h504, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h504, 32'hDEADBEEF,
             32'h55AA, 32'h1820, 5'd7, 5'd3));
      IF_ID_instr = 32'h8C24FFF0;
      IF_ID_npc = 32'h508;
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_WriteReg = 5'd7;
      MEM_WB_WriteData = 32'h9999;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst stall", {31'd0, stall}, 32'd0);
      cmp("arst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      MEM_WB_RegWrite = 1'b0;
      @(posedge clk);
      #1;
      cyc("post", 32'h00A71820, 32'h600, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h600, 0, 0,
             32'h1820, 5'd7, 5'd3));
      cyc("post2", 32'h00220820, 32'h604, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0,
          mk(2'b10, 0, 4'b1100, 32'h604, 0, 0,
             32'h0820, 5'd2, 5'd1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
